bandai2003_eeprom_master: RTL and testbench

- Serial (Microwire, 93C46-class) EEPROM master for the cartridge mapper.
- Sits directly downstream of the mapper's I/O port decode: it consumes the decoded port writes and reads for the EEPROM port group, and drives the external EEPROM pins.
- A host loads command and data registers, then triggers a transaction. The block shifts the transaction out and in, polls for write completion, and reports status.

---
 rtl/bandai2003_eeprom_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_bandai2003_eeprom_master.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bandai2003_eeprom_master.sv
// -----------------------------------------------------------------------------
// bandai2003_eeprom_master
//
// Microwire (93C46-class) serial EEPROM master for the cartridge mapper. The
// host loads DATA and CMD through the decoded mapper port, then writes CTRL to
// launch a READ, WRITE or command-only transaction. The block clocks the
// command out, shifts data out or in, optionally polls the EEPROM ready
// status, and reports completion through STATUS.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset, aborts any transaction
//   port_we_i      single-cycle register write strobe
//   port_sel_i     register select: 0 DATA_LO, 1 DATA_HI, 2 CMD_LO,
//                  3 CMD_HI, 4 CTRL (write) / STATUS (read)
//   port_wdata_i   register write data
//   port_rdata_o   combinational read of the selected register (5-7 read 0)
//   ee_cs_o        EEPROM chip select, active-high
//   ee_sk_o        EEPROM serial clock
//   ee_di_o        serial data to the EEPROM
//   ee_do_i        serial data from the EEPROM (asynchronous)
//   busy_o         transaction in progress
//
// CLK_DIV must be 3 or more; 3+ADDR_BITS must not exceed 13; DATA_BITS is 16.
// -----------------------------------------------------------------------------
module bandai2003_eeprom_master #(
  parameter int CLK_DIV      = 4,
  parameter int ADDR_BITS    = 6,
  parameter int DATA_BITS    = 16,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       port_we_i,
  input  logic [2:0] port_sel_i,
  input  logic [7:0] port_wdata_i,
  output logic [7:0] port_rdata_o,
  output logic       ee_cs_o,
  output logic       ee_sk_o,
  output logic       ee_di_o,
  input  logic       ee_do_i,
  output logic       busy_o
);

  localparam int DW       = DATA_BITS;
  localparam int CMD_BITS = 3 + ADDR_BITS;
  // One counter serves both SK half-periods and the 2*CLK_DIV CS gap.
  localparam int DIV_W    = $clog2(2 * CLK_DIV);
  localparam int POLL_W   = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_CMD,
    S_SHIFT_WR,
    S_SHIFT_RD,
    S_CS_GAP,
    S_POLL,
    S_FINISH
  } state_t;

  state_t            state_q;
  logic [DW-1:0]     data_q;
  logic [15:0]       cmd_q;
  logic              done_q;
  logic              timeout_q;
  logic              busy_q;
  logic              cs_q;
  logic              sk_q;
  logic              di_q;
  logic              mode_rd_q;
  logic              mode_wr_q;
  logic              mode_poll_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        bit_q;
  logic [POLL_W-1:0] poll_q;
  logic              do_meta_q;
  logic              do_sync_q;

  logic wr_ok;
  logic ctrl_start;
  logic phase_end;
  logic last_cell;

  // Register writes are only honoured while idle; this also drops a write
  // that lands on the FINISH cycle, since busy is still high there.
  assign wr_ok      = port_we_i && !busy_q;
  assign ctrl_start = wr_ok && (port_sel_i == 3'd4) && (|port_wdata_i[6:4]);
  assign phase_end  = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_cell  = (state_q == S_SHIFT_CMD) ? (bit_q == 4'(CMD_BITS - 1))
                                                : (bit_q == 4'd15);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      cmd_q       <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      sk_q        <= 1'b0;
      di_q        <= 1'b0;
      mode_rd_q   <= 1'b0;
      mode_wr_q   <= 1'b0;
      mode_poll_q <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      poll_q      <= '0;
      do_meta_q   <= 1'b0;
      do_sync_q   <= 1'b0;
    end else begin
      do_meta_q <= ee_do_i;
      do_sync_q <= do_meta_q;

      if (wr_ok) begin
        case (port_sel_i)
          3'd0:    data_q[7:0]  <= port_wdata_i;
          3'd1:    data_q[15:8] <= port_wdata_i;
          3'd2:    cmd_q[7:0]   <= port_wdata_i;
          3'd3:    cmd_q[15:8]  <= port_wdata_i;
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (ctrl_start) begin
            // READ beats WRITE beats CMD_ONLY; POLL only matters for CMD_ONLY.
            mode_rd_q   <= port_wdata_i[4];
            mode_wr_q   <= !port_wdata_i[4] && port_wdata_i[5];
            mode_poll_q <= port_wdata_i[7];
            busy_q      <= 1'b1;
            cs_q        <= 1'b1;
            sk_q        <= 1'b0;
            di_q        <= cmd_q[CMD_BITS-1];
            div_q       <= '0;
            bit_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            state_q     <= S_SHIFT_CMD;
          end
        end

        S_SHIFT_CMD, S_SHIFT_WR, S_SHIFT_RD: begin
          if (!phase_end) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sk_q) begin
              sk_q <= 1'b1;
            end else begin
              // End of a bit cell: SK drops and DI moves to the next bit.
              sk_q  <= 1'b0;
              bit_q <= bit_q + 4'd1;
              if (state_q == S_SHIFT_RD) begin
                data_q <= {data_q[DW-2:0], do_sync_q};
              end
              if (state_q == S_SHIFT_WR) begin
                // Rotate so DATA holds the written word again at the end.
                data_q <= {data_q[DW-2:0], data_q[DW-1]};
              end
              if (!last_cell) begin
                case (state_q)
                  S_SHIFT_CMD: di_q <= cmd_q[4'(CMD_BITS - 2) - bit_q];
                  S_SHIFT_WR:  di_q <= data_q[DW-2];
                  default:     di_q <= 1'b0;
                endcase
              end else begin
                bit_q <= '0;
                di_q  <= 1'b0;
                if (state_q == S_SHIFT_CMD && mode_rd_q) begin
                  state_q <= S_SHIFT_RD;
                end else if (state_q == S_SHIFT_CMD && mode_wr_q) begin
                  state_q <= S_SHIFT_WR;
                  di_q    <= data_q[DW-1];
                end else if (state_q == S_SHIFT_WR ||
                             (state_q == S_SHIFT_CMD && mode_poll_q)) begin
                  state_q <= S_CS_GAP;
                  cs_q    <= 1'b0;
                end else begin
                  state_q <= S_FINISH;
                  cs_q    <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
        end

        S_CS_GAP: begin
          if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
            div_q   <= '0;
            cs_q    <= 1'b1;
            poll_q  <= '0;
            state_q <= S_POLL;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_POLL: begin
          // A ready EEPROM drives DO high while selected with SK idle.
          if (do_sync_q) begin
            cs_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else if (poll_q == POLL_W'(BUSY_TIMEOUT - 1)) begin
            cs_q      <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            poll_q <= poll_q + POLL_W'(1);
          end
        end

        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    port_rdata_o = '0;
    case (port_sel_i)
      3'd0:    port_rdata_o = data_q[7:0];
      3'd1:    port_rdata_o = data_q[15:8];
      3'd2:    port_rdata_o = cmd_q[7:0];
      3'd3:    port_rdata_o = cmd_q[15:8];
      3'd4:    port_rdata_o = {5'd0, timeout_q, busy_q, done_q};
      default: port_rdata_o = '0;
    endcase
  end

  assign ee_cs_o = cs_q;
  assign ee_sk_o = sk_q;
  assign ee_di_o = di_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_bandai2003_eeprom_master.sv
// -----------------------------------------------------------------------------
// Testbench for bandai2003_eeprom_master. dut0 uses default parameters and
// talks to a behavioural 93C46-style model; dut1 uses BUSY_TIMEOUT=100 with DO
// stuck low. Stimulus pushes expected transactions and register probes into
// queues; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bandai2003_eeprom_master;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] sel;
  logic [7:0] wdata;
  logic [1:0] we;
  logic [1:0] preq;
  logic [7:0] rdata0, rdata1;
  logic [1:0] cs, sk, di, busy;
  logic       do0;
  logic       do1;

  bandai2003_eeprom_master dut0 (
    .clk_i(clk), .rst_i(rst), .port_we_i(we[0]), .port_sel_i(sel),
    .port_wdata_i(wdata), .port_rdata_o(rdata0), .ee_cs_o(cs[0]),
    .ee_sk_o(sk[0]), .ee_di_o(di[0]), .ee_do_i(do0), .busy_o(busy[0])
  );

  bandai2003_eeprom_master #(.BUSY_TIMEOUT(100)) dut1 (
    .clk_i(clk), .rst_i(rst), .port_we_i(we[1]), .port_sel_i(sel),
    .port_wdata_i(wdata), .port_rdata_o(rdata1), .ee_cs_o(cs[1]),
    .ee_sk_o(sk[1]), .ee_di_o(di[1]), .ee_do_i(do1), .busy_o(busy[1])
  );

  assign do1 = 1'b0;

  // ---------------------------------------------------------------- model
  logic [15:0] mem [64];
  int          m_cnt;
  int          m_busy;
  logic [8:0]  m_cmd;
  logic [15:0] m_wsh;
  logic [15:0] m_word;
  logic        m_cs_p = 1'b0;
  logic        m_sk_p = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_cnt  = 0;
      m_busy = 0;
      m_cmd  = '0;
      do0    = 1'b0;
    end else begin
      if (m_busy > 0) m_busy--;
      if (cs[0] && sk[0] && !m_sk_p) begin
        if (m_cnt < 9) begin
          m_cmd = {m_cmd[7:0], di[0]};
        end else if (m_cmd[8:6] == 3'b110) begin
          m_word = mem[m_cmd[5:0]];
          do0    = m_word[15-(m_cnt-9)];
        end else begin
          m_wsh = {m_wsh[14:0], di[0]};
        end
        m_cnt++;
      end
      if (!cs[0] && m_cs_p) begin
        if (m_cnt == 25 && m_cmd[8:6] == 3'b101) begin
          mem[m_cmd[5:0]] = m_wsh;
          m_busy          = 500;
        end
        m_cnt = 0;
      end
      if (!(cs[0] && m_cnt >= 10 && m_cmd[8:6] == 3'b110)) do0 = (m_busy == 0);
    end
    m_cs_p = cs[0];
    m_sk_p = sk[0];
  end

  // ----------------------------------------------------------- scoreboard
  typedef struct {
    string       name;
    int          pulses;
    logic [31:0] di;
    int          busy_n;   // -1: not checked
    int          cs_low;
    int          poll_lo;
    int          poll_hi;
  } txn_t;

  typedef struct {
    string name;
    int    kind;           // 0 rdata, 1 pins {cs,sk,di,busy}, 2 stray SK, 3 model mem
    int    addr;
    int    val;
  } probe_t;

  txn_t   exp_q0[$], exp_q1[$];
  probe_t probe_q0[$], probe_q1[$];

  int checks   = 0;
  int failures = 0;

  int          pulses [2];
  logic [31:0] di_w   [2];
  int          busy_n [2];
  int          cs_low [2];
  int          poll_n [2];
  int          hi_run [2];
  int          stray  [2] = '{0, 0};
  bit          gap    [2];
  bit          hi_bad [2];
  logic        busy_p [2] = '{1'b0, 1'b0};
  logic        sk_p   [2] = '{1'b0, 1'b0};

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, got);
    end
  endtask

  task automatic mon_step(input int d);
    txn_t   t;
    probe_t p;
    bit     have;
    int     got;
    if (preq[d]) begin
      have = 1'b0;
      if (d == 0 && probe_q0.size() > 0) begin p = probe_q0.pop_front(); have = 1'b1; end
      if (d == 1 && probe_q1.size() > 0) begin p = probe_q1.pop_front(); have = 1'b1; end
      if (!have) begin
        checks++; failures++;
        $display("FAIL probe_underflow dut%0d got=probe required=expectation", d);
      end else begin
        case (p.kind)
          0:       got = (d == 0) ? int'(rdata0) : int'(rdata1);
          1:       got = int'({cs[d], sk[d], di[d], busy[d]});
          2:       got = stray[d];
          default: got = int'(mem[p.addr]);
        endcase
        check(p.name, got, p.val);
      end
    end
    if (sk[d] && !sk_p[d] && !busy[d]) stray[d]++;
    if (rst) begin
      busy_p[d] = 1'b0;
    end else begin
      if (busy[d] && !busy_p[d]) begin
        pulses[d] = 0; di_w[d] = '0; busy_n[d] = 0; cs_low[d] = 0;
        poll_n[d] = 0; gap[d] = 1'b0; hi_run[d] = 0; hi_bad[d] = 1'b0;
      end
      if (busy[d]) begin
        busy_n[d]++;
        if (!cs[d]) begin
          cs_low[d]++;
          gap[d] = 1'b1;
        end else if (gap[d]) begin
          poll_n[d]++;
        end
        if (sk[d] && !sk_p[d]) begin
          pulses[d]++;
          di_w[d] = {di_w[d][30:0], di[d]};
        end
      end
      if (sk[d]) hi_run[d]++;
      else begin
        if (sk_p[d] && hi_run[d] != CLK_DIV) hi_bad[d] = 1'b1;
        hi_run[d] = 0;
      end
      if (!busy[d] && busy_p[d]) begin
        have = 1'b0;
        if (d == 0 && exp_q0.size() > 0) begin t = exp_q0.pop_front(); have = 1'b1; end
        if (d == 1 && exp_q1.size() > 0) begin t = exp_q1.pop_front(); have = 1'b1; end
        if (!have) begin
          checks++; failures++;
          $display("FAIL unexpected_txn dut%0d got=transaction required=none", d);
        end else begin
          check({t.name, "_sk_pulses"}, pulses[d], t.pulses);
          check({t.name, "_di_bits"}, di_w[d], t.di);
          check({t.name, "_sk_high_width_bad"}, hi_bad[d], 0);
          check({t.name, "_cs_low_cycles"}, cs_low[d], t.cs_low);
          if (t.busy_n >= 0) check({t.name, "_busy_cycles"}, busy_n[d], t.busy_n);
          checks++;
          if (poll_n[d] < t.poll_lo || poll_n[d] > t.poll_hi) begin
            failures++;
            $display("FAIL %s_poll_cycles got=%0d required=%0d..%0d",
                     t.name, poll_n[d], t.poll_lo, t.poll_hi);
          end else begin
            $display("ok   %s_poll_cycles = %0d", t.name, poll_n[d]);
          end
        end
      end
      busy_p[d] = busy[d];
    end
    sk_p[d] = sk[d];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input int d, input logic [2:0] s, input logic [7:0] v);
    sel   = s;
    wdata = v;
    we[d] = 1'b1;
    tick();
    we[d] = 1'b0;
  endtask

  task automatic probe(input int d, input string name, input int kind,
                       input logic [2:0] s, input int addr, input int val);
    probe_t p;
    p.name = name; p.kind = kind; p.addr = addr; p.val = val;
    if (d == 0) probe_q0.push_back(p); else probe_q1.push_back(p);
    sel     = s;
    preq[d] = 1'b1;
    tick();
    preq[d] = 1'b0;
  endtask

  task automatic expect_txn(input int d, input string name, input int pulses_e,
                            input logic [31:0] di_e, input int busy_e,
                            input int cs_low_e, input int poll_lo, input int poll_hi);
    txn_t t;
    t.name = name; t.pulses = pulses_e; t.di = di_e; t.busy_n = busy_e;
    t.cs_low = cs_low_e; t.poll_lo = poll_lo; t.poll_hi = poll_hi;
    if (d == 0) exp_q0.push_back(t); else exp_q1.push_back(t);
  endtask

  task automatic wait_idle(input int d, input int budget, input string name);
    int n = 0;
    while (busy[d] && n < budget) begin
      tick();
      n++;
    end
    if (busy[d]) begin
      checks++; failures++;
      $display("FAIL %s_wait busy=1 after %0d cycles required=0", name, budget);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[5] = 16'hA55A;
    rst = 1'b1; sel = '0; wdata = '0; we = '0; preq = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    probe(0, "reset_pins", 1, 3'd0, 0, 0);
    probe(0, "reset_status", 0, 3'd4, 0, 8'h00);
    probe(0, "reset_data_hi", 0, 3'd1, 0, 8'h00);
    probe(1, "reset_status_dut1", 0, 3'd4, 0, 8'h00);

    // READ address 5
    reg_wr(0, 3'd2, 8'h85);
    reg_wr(0, 3'd3, 8'h01);
    expect_txn(0, "read", 25, 32'h0185_0000, 201, 1, 0, 0);
    reg_wr(0, 3'd4, 8'h10);
    wait_idle(0, 400, "read");
    probe(0, "read_data_lo", 0, 3'd0, 0, 8'h5A);
    probe(0, "read_data_hi", 0, 3'd1, 0, 8'hA5);
    probe(0, "read_status", 0, 3'd4, 0, 8'h01);

    // WRITE 0x1234 to address 3, model busy for 500 cycles
    reg_wr(0, 3'd2, 8'h43);
    reg_wr(0, 3'd3, 8'h01);
    reg_wr(0, 3'd0, 8'h34);
    reg_wr(0, 3'd1, 8'h12);
    expect_txn(0, "write", 25, 32'h0143_1234, -1, 9, 480, 510);
    reg_wr(0, 3'd4, 8'h20);
    wait_idle(0, 2000, "write");
    probe(0, "write_status", 0, 3'd4, 0, 8'h01);
    probe(0, "write_model_word3", 3, 3'd0, 3, 16'h1234);

    // EWEN, command only, no poll then with poll
    reg_wr(0, 3'd2, 8'h30);
    reg_wr(0, 3'd3, 8'h01);
    expect_txn(0, "ewen", 9, 32'h0000_0130, 73, 1, 0, 0);
    reg_wr(0, 3'd4, 8'h40);
    wait_idle(0, 200, "ewen");
    probe(0, "ewen_status", 0, 3'd4, 0, 8'h01);
    expect_txn(0, "ewen_poll", 9, 32'h0000_0130, 82, 9, 1, 1);
    reg_wr(0, 3'd4, 8'hC0);
    wait_idle(0, 200, "ewen_poll");
    probe(0, "ewen_poll_status", 0, 3'd4, 0, 8'h01);

    // Priority (0x70 is a READ) and busy write protection
    reg_wr(0, 3'd2, 8'h83);
    expect_txn(0, "prio_read", 25, 32'h0183_0000, 201, 1, 0, 0);
    reg_wr(0, 3'd4, 8'h70);
    repeat (20) tick();
    reg_wr(0, 3'd0, 8'hFF);
    reg_wr(0, 3'd2, 8'hFF);
    reg_wr(0, 3'd4, 8'h20);
    wait_idle(0, 400, "prio_read");
    probe(0, "prio_data_lo", 0, 3'd0, 0, 8'h34);
    probe(0, "prio_data_hi", 0, 3'd1, 0, 8'h12);
    probe(0, "prio_cmd_lo_kept", 0, 3'd2, 0, 8'h83);
    probe(0, "prio_status", 0, 3'd4, 0, 8'h01);
    repeat (20) tick();
    probe(0, "prio_no_second_txn", 1, 3'd0, 0, 0);

    // Poll timeout on dut1 (BUSY_TIMEOUT=100, DO stuck low)
    reg_wr(1, 3'd2, 8'h47);
    reg_wr(1, 3'd3, 8'h01);
    reg_wr(1, 3'd0, 8'hFE);
    reg_wr(1, 3'd1, 8'hCA);
    expect_txn(1, "timeout", 25, 32'h0147_CAFE, 309, 9, 100, 100);
    reg_wr(1, 3'd4, 8'h20);
    wait_idle(1, 1000, "timeout");
    probe(1, "timeout_status", 0, 3'd4, 0, 8'h05);
    probe(1, "timeout_pins", 1, 3'd0, 0, 0);

    // Reset in the middle of SHIFT_WR
    reg_wr(0, 3'd2, 8'h42);
    reg_wr(0, 3'd0, 8'hEF);
    reg_wr(0, 3'd1, 8'hBE);
    reg_wr(0, 3'd4, 8'h20);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    probe(0, "abort_pins", 1, 3'd0, 0, 0);
    probe(0, "abort_status", 0, 3'd4, 0, 8'h00);
    probe(0, "abort_data_hi", 0, 3'd1, 0, 8'h00);
    probe(0, "abort_cmd_lo", 0, 3'd2, 0, 8'h00);
    repeat (100) tick();
    probe(0, "abort_no_sk_edges", 2, 3'd0, 0, 0);
    probe(0, "abort_no_commit", 3, 3'd0, 2, 16'h0000);

    repeat (4) tick();
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL pending_txns got=%0d required=0", exp_q0.size() + exp_q1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
